// File: rtl/exe_stage_md.sv
// rtl/exe_stage_md.sv - pipeline execute stage with multi-cycle divider, store strobes and forwarding
//
// Purpose:
//   Execute stage between ID and MEM. It holds one instruction and computes its ALU
//   result combinationally. Divide/modulo ops instead run a restoring divider that
//   produces one quotient bit per cycle and stalls the stage until the result is ready.
//   It also drives the data SRAM request with size-aware byte strobes and replicated
//   store data. A forwarding bus reports the in-flight destination and its result.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   EXE_flush         kill the instruction currently held in EXE
//   EXE_allow_in      EXE can take an instruction from ID this cycle
//   ID_to_EXE_valid   ID presents a valid instruction on ID_to_EXE_bus
//   EXE_to_MEM_valid  EXE presents a finished instruction on EXE_to_MEM_bus
//   MEM_allow_in      MEM can accept an instruction
//   data_sram_*       data SRAM enable, byte strobes, address, write data
//   EXE_fwd_bus       {wr_valid, is_load, res_valid, dest, result}
module exe_stage_md #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ID_BUS_W   = 21 + REG_ADDR_W + 4*XLEN + 32,
  parameter int MEM_BUS_W  = 2*XLEN + REG_ADDR_W + 36
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       EXE_flush,
  output logic                       EXE_allow_in,
  input  logic                       ID_to_EXE_valid,
  input  logic [ID_BUS_W-1:0]        ID_to_EXE_bus,
  output logic                       EXE_to_MEM_valid,
  input  logic                       MEM_allow_in,
  output logic [MEM_BUS_W-1:0]       EXE_to_MEM_bus,
  output logic                       data_sram_en,
  output logic [XLEN/8-1:0]          data_sram_we,
  output logic [XLEN-1:0]            data_sram_addr,
  output logic [XLEN-1:0]            data_sram_wdata,
  output logic [3+REG_ADDR_W+XLEN-1:0] EXE_fwd_bus
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int SH_W   = $clog2(XLEN);
  localparam int CNT_W  = $clog2(XLEN);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  logic                  exe_valid;
  logic [ID_BUS_W-1:0]   payload;

  logic [11:0]           alu_op;
  logic [3:0]            div_op;
  logic [1:0]            mem_size;
  logic                  mem_we, res_from_mem, gr_we;
  logic [REG_ADDR_W-1:0] dest;
  logic [XLEN-1:0]       alu_src1, alu_src2, rkd_value, pc;
  logic [31:0]           inst;

  assign {alu_op, div_op, mem_size, mem_we, res_from_mem, gr_we, dest,
          alu_src1, alu_src2, rkd_value, pc, inst} = payload;

  // ---------------- ALU (alu_op one-hot: add sub slt sltu and nor or xor sll srl sra lui) ----
  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] sra_res, alu_result;
  assign shamt   = alu_src2[SH_W-1:0];
  assign sra_res = $unsigned($signed(alu_src1) >>> shamt);

  assign alu_result =
      ({XLEN{alu_op[0]}}  & (alu_src1 + alu_src2))
    | ({XLEN{alu_op[1]}}  & (alu_src1 - alu_src2))
    | ({XLEN{alu_op[2]}}  & XLEN'($signed(alu_src1) < $signed(alu_src2)))
    | ({XLEN{alu_op[3]}}  & XLEN'(alu_src1 < alu_src2))
    | ({XLEN{alu_op[4]}}  & (alu_src1 & alu_src2))
    | ({XLEN{alu_op[5]}}  & ~(alu_src1 | alu_src2))
    | ({XLEN{alu_op[6]}}  & (alu_src1 | alu_src2))
    | ({XLEN{alu_op[7]}}  & (alu_src1 ^ alu_src2))
    | ({XLEN{alu_op[8]}}  & (alu_src1 << shamt))
    | ({XLEN{alu_op[9]}}  & (alu_src1 >> shamt))
    | ({XLEN{alu_op[10]}} & sra_res)
    | ({XLEN{alu_op[11]}} & alu_src2);

  // ---------------- Restoring divider (div_op one-hot: modu mod divu div) ----------------
  div_state_t      div_state;
  logic [XLEN-1:0] div_quo, div_rem, div_dvsr;
  logic            div_qneg, div_rneg;
  logic [CNT_W-1:0] div_cnt;

  logic            is_div, div_signed, s1_neg, s2_neg;
  logic [XLEN:0]   div_shift, div_diff;
  logic [XLEN-1:0] quo_fix, rem_fix, div_result, exe_result;
  logic            ready_go, to_mem_fire;

  assign is_div     = |div_op;
  assign div_signed = div_op[0] | div_op[2];
  assign s1_neg     = div_signed & alu_src1[XLEN-1];
  assign s2_neg     = div_signed & alu_src2[XLEN-1];

  // Partial remainder shifted left with the next dividend bit; a clear top bit of
  // the difference means the divisor fits and the quotient bit is 1.
  assign div_shift = {div_rem, div_quo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, div_dvsr};

  // Divide by zero must read as all ones regardless of operand signs.
  assign quo_fix    = (div_dvsr == '0) ? '1 : (div_qneg ? -div_quo : div_quo);
  assign rem_fix    = div_rneg ? -div_rem : div_rem;
  assign div_result = (div_op[2] | div_op[3]) ? rem_fix : quo_fix;
  assign exe_result = is_div ? div_result : alu_result;

  assign ready_go         = ~is_div | (div_state == DIV_DONE);
  assign EXE_allow_in     = ~exe_valid | (ready_go & MEM_allow_in);
  assign EXE_to_MEM_valid = exe_valid & ready_go & ~EXE_flush;
  assign to_mem_fire      = EXE_to_MEM_valid & MEM_allow_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_state <= DIV_IDLE;
      div_quo   <= '0;
      div_rem   <= '0;
      div_dvsr  <= '0;
      div_qneg  <= 1'b0;
      div_rneg  <= 1'b0;
      div_cnt   <= '0;
    end else if (EXE_flush) begin
      div_state <= DIV_IDLE;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (exe_valid && is_div) begin
            div_quo   <= s1_neg ? -alu_src1 : alu_src1;
            div_dvsr  <= s2_neg ? -alu_src2 : alu_src2;
            div_rem   <= '0;
            div_qneg  <= s1_neg ^ s2_neg;
            div_rneg  <= s1_neg;
            div_cnt   <= CNT_W'(XLEN - 1);
            div_state <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          div_quo <= {div_quo[XLEN-2:0], ~div_diff[XLEN]};
          div_rem <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
          div_cnt <= div_cnt - 1'b1;
          if (div_cnt == '0) div_state <= DIV_DONE;
        end
        DIV_DONE: begin
          if (to_mem_fire) div_state <= DIV_IDLE;
        end
        default: div_state <= DIV_IDLE;
      endcase
    end
  end

  // ---------------- Pipeline register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      exe_valid <= 1'b0;
      payload   <= '0;
    end else if (EXE_flush) begin
      exe_valid <= 1'b0;
    end else if (EXE_allow_in) begin
      exe_valid <= ID_to_EXE_valid;
      if (ID_to_EXE_valid) payload <= ID_to_EXE_bus;
    end
  end

  // ---------------- Data SRAM request ----------------
  logic [1:0]        eff_size;
  logic              aligned;
  logic [STRB_W-1:0] base_strb;

  // A dword request on a 32-bit datapath behaves as a word.
  assign eff_size = (XLEN == 32 && mem_size == 2'b11) ? 2'b10 : mem_size;

  always_comb begin
    aligned         = 1'b1;
    base_strb       = '1;
    data_sram_wdata = rkd_value;
    case (eff_size)
      2'b00: begin
        base_strb       = STRB_W'(1);
        data_sram_wdata = {(XLEN/8){rkd_value[7:0]}};
      end
      2'b01: begin
        aligned         = ~alu_result[0];
        base_strb       = STRB_W'(3);
        data_sram_wdata = {(XLEN/16){rkd_value[15:0]}};
      end
      2'b10: begin
        aligned         = (alu_result[1:0] == 2'b00);
        base_strb       = STRB_W'(15);
        data_sram_wdata = {(XLEN/32){rkd_value[31:0]}};
      end
      default: begin
        aligned         = (alu_result[2:0] == 3'b000);
        base_strb       = '1;
        data_sram_wdata = rkd_value;
      end
    endcase
  end

  assign data_sram_en   = exe_valid & (mem_we | res_from_mem) & ~EXE_flush;
  assign data_sram_we   = (exe_valid & mem_we & ~EXE_flush & aligned)
                          ? (base_strb << alu_result[OFF_W-1:0]) : '0;
  assign data_sram_addr = alu_result;

  // ---------------- Outputs to MEM and forwarding ----------------
  logic wr_valid, is_load, res_valid;
  assign wr_valid  = exe_valid & gr_we & ~EXE_flush;
  assign is_load   = exe_valid & res_from_mem & ~EXE_flush;
  assign res_valid = wr_valid & ~res_from_mem & ready_go;

  assign EXE_to_MEM_bus = {exe_result, res_from_mem, mem_size, gr_we, dest, pc, inst};
  assign EXE_fwd_bus    = {wr_valid, is_load, res_valid, dest, exe_result};

endmodule

// File: tb/tb_exe_stage_md.sv
// tb/tb_exe_stage_md.sv - self-checking bench for exe_stage_md
module tb_exe_stage_md;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int IDW  = 21 + RW + 4*XLEN + 32;
  localparam int MEMW = 2*XLEN + RW + 36;
  localparam int FWDW = 3 + RW + XLEN;

  localparam logic [11:0] A_ADD = 12'h001, A_SUB = 12'h002, A_SLT = 12'h004, A_SLTU = 12'h008,
                          A_AND = 12'h010, A_NOR = 12'h020, A_OR  = 12'h040, A_XOR  = 12'h080,
                          A_SLL = 12'h100, A_SRL = 12'h200, A_SRA = 12'h400, A_LUI  = 12'h800;
  localparam logic [3:0]  D_DIV = 4'b0001, D_DIVU = 4'b0010, D_MOD = 4'b0100, D_MODU = 4'b1000;

  logic            clk = 1'b0;
  logic            reset;
  logic            EXE_flush;
  logic            EXE_allow_in;
  logic            ID_to_EXE_valid;
  logic [IDW-1:0]  ID_to_EXE_bus;
  logic            EXE_to_MEM_valid;
  logic            MEM_allow_in;
  logic [MEMW-1:0] EXE_to_MEM_bus;
  logic            data_sram_en;
  logic [3:0]      data_sram_we;
  logic [31:0]     data_sram_addr;
  logic [31:0]     data_sram_wdata;
  logic [FWDW-1:0] EXE_fwd_bus;

  exe_stage_md #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk(clk), .reset(reset), .EXE_flush(EXE_flush), .EXE_allow_in(EXE_allow_in),
    .ID_to_EXE_valid(ID_to_EXE_valid), .ID_to_EXE_bus(ID_to_EXE_bus),
    .EXE_to_MEM_valid(EXE_to_MEM_valid), .MEM_allow_in(MEM_allow_in),
    .EXE_to_MEM_bus(EXE_to_MEM_bus), .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata), .EXE_fwd_bus(EXE_fwd_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] alu_op;
    logic [3:0]  div_op;
    logic [1:0]  size;
    logic        we, rfm, gr_we;
    logic [4:0]  dest;
    logic [31:0] src1, src2, rkd;
    logic [31:0] exp_res;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] result, pc, wdata;
    logic [4:0]  dest;
    logic        en, chk_wdata;
    logic [3:0]  we;
    logic [2:0]  fwdv;
  } sb_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   retire_cnt = 0;
  int   last_ret = 0, prev_ret = 0;
  logic [31:0] pc_next = 32'h1c00_0000;
  sb_t  sb[$];
  vec_t vecs[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [11:0] a, input logic [3:0] d, input logic [1:0] sz,
                              input logic we, input logic rfm, input logic gr, input logic [4:0] ds,
                              input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] rk,
                              input logic [31:0] er, input logic [3:0] ew, input logic [31:0] ewd);
    vec_t v;
    v.alu_op = a; v.div_op = d; v.size = sz; v.we = we; v.rfm = rfm; v.gr_we = gr; v.dest = ds;
    v.src1 = s1; v.src2 = s2; v.rkd = rk; v.exp_res = er; v.exp_we = ew; v.exp_wdata = ewd;
    return v;
  endfunction

  function automatic logic [IDW-1:0] pack(input vec_t v, input logic [31:0] pc);
    return {v.alu_op, v.div_op, v.size, v.we, v.rfm, v.gr_we, v.dest,
            v.src1, v.src2, v.rkd, pc, pc};
  endfunction

  // Present one instruction until ID->EXE handshake completes; returns at posedge+1.
  task automatic send(input vec_t v, input bit push);
    sb_t e;
    bit  ok = 1'b0;
    ID_to_EXE_bus   = pack(v, pc_next);
    ID_to_EXE_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (EXE_allow_in) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    ID_to_EXE_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
    else if (push) begin
      e.result = v.exp_res; e.pc = pc_next; e.dest = v.dest;
      e.en = v.we | v.rfm; e.we = v.exp_we; e.wdata = v.exp_wdata; e.chk_wdata = v.we;
      e.fwdv = {v.gr_we, v.rfm, v.gr_we & ~v.rfm};
      sb.push_back(e);
    end
    pc_next = pc_next + 32'd4;
  endtask

  // Scoreboard: every MEM acceptance pops and checks one expected record.
  always @(negedge clk) begin
    sb_t e;
    if (!reset && EXE_to_MEM_valid && MEM_allow_in) begin
      retire_cnt++;
      prev_ret = last_ret;
      last_ret = cyc;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_retire: got pc %h expected no retire", EXE_to_MEM_bus[63:32]);
      end else begin
        e = sb.pop_front();
        chk("mem_result", EXE_to_MEM_bus[104:73], e.result);
        chk("mem_pc",     EXE_to_MEM_bus[63:32],  e.pc);
        chk("mem_dest",   EXE_to_MEM_bus[68:64],  e.dest);
        chk("sram_en",    data_sram_en, e.en);
        chk("sram_we",    data_sram_we, e.we);
        if (e.chk_wdata) chk("sram_wdata", data_sram_wdata, e.wdata);
        chk("fwd_valids", EXE_fwd_bus[39:37], e.fwdv);
        chk("fwd_result", EXE_fwd_bus[31:0], e.result);
      end
    end
  end

  initial begin
    vec_t        vd;
    int          n;
    int          rc0;
    logic [31:0] held;

    reset = 1'b1; EXE_flush = 1'b0; ID_to_EXE_valid = 1'b0; ID_to_EXE_bus = '0; MEM_allow_in = 1'b1;

    //       alu    div    sz we rfm gr dst src1          src2          rkd           exp_res       we     wdata
    vecs.push_back(mk(A_ADD, 4'h0, 2'd0, 0,0,1, 5'd1, 32'd5,        32'd7,        32'h0,        32'd12,       4'h0, 32'h0));
    vecs.push_back(mk(A_ADD, 4'h0, 2'd0, 0,0,1, 5'd2, 32'd1,        32'd1,        32'h0,        32'd2,        4'h0, 32'h0));
    vecs.push_back(mk(A_SUB, 4'h0, 2'd0, 0,0,1, 5'd3, 32'd3,        32'd5,        32'h0,        32'hFFFFFFFE, 4'h0, 32'h0));
    vecs.push_back(mk(A_SLT, 4'h0, 2'd0, 0,0,1, 5'd4, 32'hFFFFFFFF, 32'd1,        32'h0,        32'd1,        4'h0, 32'h0));
    vecs.push_back(mk(A_SLTU,4'h0, 2'd0, 0,0,1, 5'd5, 32'hFFFFFFFF, 32'd1,        32'h0,        32'd0,        4'h0, 32'h0));
    vecs.push_back(mk(A_AND, 4'h0, 2'd0, 0,0,1, 5'd6, 32'hF0F0,     32'hFF00,     32'h0,        32'hF000,     4'h0, 32'h0));
    vecs.push_back(mk(A_NOR, 4'h0, 2'd0, 0,0,1, 5'd7, 32'h0,        32'h0,        32'h0,        32'hFFFFFFFF, 4'h0, 32'h0));
    vecs.push_back(mk(A_OR,  4'h0, 2'd0, 0,0,1, 5'd8, 32'hF0,       32'h0F,       32'h0,        32'hFF,       4'h0, 32'h0));
    vecs.push_back(mk(A_XOR, 4'h0, 2'd0, 0,0,1, 5'd9, 32'hFF,       32'h0F,       32'h0,        32'hF0,       4'h0, 32'h0));
    vecs.push_back(mk(A_SLL, 4'h0, 2'd0, 0,0,1, 5'd10,32'd1,        32'd4,        32'h0,        32'd16,       4'h0, 32'h0));
    vecs.push_back(mk(A_SRL, 4'h0, 2'd0, 0,0,1, 5'd11,32'h80000000, 32'd31,       32'h0,        32'd1,        4'h0, 32'h0));
    vecs.push_back(mk(A_SRA, 4'h0, 2'd0, 0,0,1, 5'd12,32'h80000000, 32'd4,        32'h0,        32'hF8000000, 4'h0, 32'h0));
    vecs.push_back(mk(A_LUI, 4'h0, 2'd0, 0,0,1, 5'd13,32'h0,        32'h12345000, 32'h0,        32'h12345000, 4'h0, 32'h0));
    vecs.push_back(mk(A_ADD, 4'h0, 2'd0, 1,0,0, 5'd0, 32'h1000,     32'd3,        32'h12345678, 32'h1003,     4'b1000, 32'h78787878));
    vecs.push_back(mk(A_ADD, 4'h0, 2'd0, 1,0,0, 5'd0, 32'h1000,     32'd0,        32'h12345678, 32'h1000,     4'b0001, 32'h78787878));
    vecs.push_back(mk(A_ADD, 4'h0, 2'd1, 1,0,0, 5'd0, 32'h1000,     32'd1,        32'h12345678, 32'h1001,     4'b0000, 32'h56785678));
    vecs.push_back(mk(A_ADD, 4'h0, 2'd1, 1,0,0, 5'd0, 32'h1000,     32'd2,        32'h12345678, 32'h1002,     4'b1100, 32'h56785678));
    vecs.push_back(mk(A_ADD, 4'h0, 2'd2, 1,0,0, 5'd0, 32'h1000,     32'd4,        32'h12345678, 32'h1004,     4'b1111, 32'h12345678));
    vecs.push_back(mk(A_ADD, 4'h0, 2'd2, 1,0,0, 5'd0, 32'h1000,     32'd2,        32'h12345678, 32'h1002,     4'b0000, 32'h12345678));
    vecs.push_back(mk(A_ADD, 4'h0, 2'd3, 1,0,0, 5'd0, 32'h1000,     32'd8,        32'h12345678, 32'h1008,     4'b1111, 32'h12345678));
    vecs.push_back(mk(A_ADD, 4'h0, 2'd2, 0,1,1, 5'd14,32'h1000,     32'd8,        32'h0,        32'h1008,     4'b0000, 32'h0));
    vecs.push_back(mk(12'h0, D_DIV,  2'd0, 0,0,1, 5'd15,32'hFFFFFFF9, 32'd2,      32'h0,        32'hFFFFFFFD, 4'h0, 32'h0));
    vecs.push_back(mk(12'h0, D_MOD,  2'd0, 0,0,1, 5'd16,32'hFFFFFFF9, 32'd2,      32'h0,        32'hFFFFFFFF, 4'h0, 32'h0));
    vecs.push_back(mk(12'h0, D_DIVU, 2'd0, 0,0,1, 5'd17,32'h1234,     32'd0,      32'h0,        32'hFFFFFFFF, 4'h0, 32'h0));
    vecs.push_back(mk(12'h0, D_MODU, 2'd0, 0,0,1, 5'd18,32'h1234,     32'd0,      32'h0,        32'h1234,     4'h0, 32'h0));
    vecs.push_back(mk(12'h0, D_DIV,  2'd0, 0,0,1, 5'd19,32'h80000000, 32'hFFFFFFFF, 32'h0,      32'h80000000, 4'h0, 32'h0));
    vecs.push_back(mk(12'h0, D_MOD,  2'd0, 0,0,1, 5'd20,32'h80000000, 32'hFFFFFFFF, 32'h0,      32'h0,        4'h0, 32'h0));
    vecs.push_back(mk(12'h0, D_DIVU, 2'd0, 0,0,1, 5'd21,32'd100,      32'd7,      32'h0,        32'd14,       4'h0, 32'h0));
    vecs.push_back(mk(12'h0, D_MODU, 2'd0, 0,0,1, 5'd22,32'd100,      32'd7,      32'h0,        32'd2,        4'h0, 32'h0));
    vecs.push_back(mk(12'h0, D_DIV,  2'd0, 0,0,1, 5'd23,32'd7,        32'hFFFFFFFE, 32'h0,      32'hFFFFFFFD, 4'h0, 32'h0));
    vecs.push_back(mk(12'h0, D_MOD,  2'd0, 0,0,1, 5'd24,32'd7,        32'hFFFFFFFE, 32'h0,      32'd1,        4'h0, 32'h0));
    vecs.push_back(mk(12'h0, D_DIV,  2'd0, 0,0,1, 5'd25,32'hFFFFFFF8, 32'd0,      32'h0,        32'hFFFFFFFF, 4'h0, 32'h0));
    vecs.push_back(mk(12'h0, D_MOD,  2'd0, 0,0,1, 5'd26,32'hFFFFFFF8, 32'd0,      32'h0,        32'hFFFFFFF8, 4'h0, 32'h0));

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_to_mem_valid", EXE_to_MEM_valid, 0);
    chk("rst_allow_in",     EXE_allow_in, 1);
    chk("rst_sram_en",      data_sram_en, 0);
    chk("rst_sram_we",      data_sram_we, 0);
    chk("rst_fwd_valids",   EXE_fwd_bus[39:37], 0);
    @(posedge clk); #1;

    // Back-to-back adds retire on consecutive cycles
    send(vecs[0], 1'b1);
    send(vecs[1], 1'b1);
    @(posedge clk); #1;
    chk("b2b_retire_gap", last_ret - prev_ret, 1);

    // Table of vectors, issued back to back through the scoreboard
    foreach (vecs[i]) send(vecs[i], 1'b1);
    for (int k = 0; k < 3000 && sb.size() != 0; k++) @(posedge clk);
    #1 chk("table_drain", sb.size(), 0);

    // Divide latency: EXE_to_MEM_valid low for XLEN+1 cycles, then high for one
    send(vecs[21], 1'b1);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (EXE_to_MEM_valid) break;
      n++;
      if (k == 5) begin
        chk("busy_fwd_wr_valid",  EXE_fwd_bus[39], 1);
        chk("busy_fwd_res_valid", EXE_fwd_bus[37], 0);
        chk("busy_allow_in",      EXE_allow_in, 0);
      end
    end
    chk("div_latency", n, 33);
    @(negedge clk);
    chk("div_one_cycle", EXE_to_MEM_valid, 0);
    @(posedge clk); #1;

    // DONE held while MEM stalls, single transfer on release
    MEM_allow_in = 1'b0;
    send(vecs[27], 1'b1);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (EXE_to_MEM_valid) break;
    end
    held = EXE_to_MEM_bus[104:73];
    chk("stall_result", held, 32'd14);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_valid_held",  EXE_to_MEM_valid, 1);
      chk("stall_result_held", EXE_to_MEM_bus[104:73], held);
      chk("stall_allow_in",    EXE_allow_in, 0);
    end
    @(posedge clk); #1;
    rc0 = retire_cnt;
    MEM_allow_in = 1'b1;
    @(posedge clk); #1;
    chk("stall_one_transfer", retire_cnt, rc0 + 1);
    @(negedge clk);
    chk("stall_after_release", EXE_to_MEM_valid, 0);
    @(posedge clk); #1;

    // Flush in BUSY cycle 10, with a stray ID instruction that must be ignored
    send(vecs[27], 1'b0);
    repeat (10) @(posedge clk);
    #1;
    EXE_flush = 1'b1;
    vd = vecs[15];
    vd.gr_we = 1'b1;
    ID_to_EXE_bus = pack(vd, 32'hDEAD0000);
    ID_to_EXE_valid = 1'b1;
    @(negedge clk);
    chk("flush_to_mem_valid", EXE_to_MEM_valid, 0);
    chk("flush_sram_en",      data_sram_en, 0);
    chk("flush_fwd_valids",   EXE_fwd_bus[39:37], 0);
    @(posedge clk); #1;
    EXE_flush = 1'b0;
    ID_to_EXE_valid = 1'b0;
    @(negedge clk);
    chk("post_flush_valid",    EXE_to_MEM_valid, 0);
    chk("post_flush_allow_in", EXE_allow_in, 1);
    @(posedge clk); #1;
    vd = mk(A_ADD, 4'h0, 2'd0, 0,0,1, 5'd9, 32'd20, 32'd22, 32'h0, 32'd42, 4'h0, 32'h0);
    send(vd, 1'b1);
    @(negedge clk);
    chk("add_after_flush_latency", EXE_to_MEM_valid, 1);
    @(posedge clk); #1;

    for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1 chk("final_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
